// File: rtl/ladybird_config.sv
// ladybird_config -- shared configuration for the ladybird fetch path.
//   XLEN          : machine word width used by all fetch-path buses
//   fetch_state_e : fetch FSM states (RUN, DRAIN)
//   word_align()  : clears the two byte-offset bits of an address
package ladybird_config;

  localparam int XLEN = 32;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ladybird_mem_if.sv
// ladybird_mem_if -- simple request/grant memory bus with in-order responses.
//   req/addr/wstrb : request side, driven by the primary
//   gnt            : request accepted this cycle
//   data_gnt/data  : response valid and its read data
interface ladybird_mem_if;
  import ladybird_config::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic [XLEN/8-1:0] wstrb;
  logic            gnt;
  logic            data_gnt;
  logic [XLEN-1:0] data;

  modport primary   (output req, addr, wstrb, input  gnt, data_gnt, data);
  modport secondary (input  req, addr, wstrb, output gnt, data_gnt, data);
endinterface

// File: rtl/ladybird_fetch_fifo.sv
// ladybird_fetch_fifo -- DEPTH-entry storage of {pc, inst} pairs.
//   clk, anrst          : clock, asynchronous active-low reset
//   push, push_pc/inst  : write one entry (ignored when full without pop)
//   pop                 : retire the head entry (ignored when empty)
//   flush               : empty the queue; overrides push and pop
//   full, empty, count  : occupancy status
//   head_pc, head_inst  : head entry, forced to zero when empty
module ladybird_fetch_fifo
  import ladybird_config::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       anrst,
  input  logic                       push,
  input  logic [XLEN-1:0]            push_pc,
  input  logic [XLEN-1:0]            push_inst,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [XLEN-1:0]            head_pc,
  output logic [XLEN-1:0]            head_inst
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [XLEN-1:0] mem_inst [DEPTH];
  logic            do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  // A full queue may still accept a push when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_pc[wr_ptr]   <= push_pc;
      mem_inst[wr_ptr] <= push_inst;
    end
  end

  assign head_pc   = empty ? '0 : mem_pc[rd_ptr];
  assign head_inst = empty ? '0 : mem_inst[rd_ptr];

endmodule

// File: rtl/ladybird_fetch_queue.sv
// ladybird_fetch_queue -- instruction prefetch queue with redirect support.
//   clk, anrst        : clock, asynchronous active-low reset
//   inst              : fetch bus (primary side), in-order responses
//   redirect_valid/pc : flush and restart fetch at redirect_pc (word aligned)
//   o_valid/inst/pc   : head instruction presented to the consumer
//   i_ready           : consumer takes the head this cycle
// Optional macro LADYBIRD_FETCH_BYPASS_EN: a response arriving at an empty
// queue is presented on the outputs in the same cycle.
module ladybird_fetch_queue
  import ladybird_config::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter bit              SIMULATION      = 1'b0
) (
  input  logic             clk,
  input  logic             anrst,
  ladybird_mem_if.primary  inst,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             o_valid,
  output logic [XLEN-1:0]  o_inst,
  output logic [XLEN-1:0]  o_pc,
  input  logic             i_ready
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_e    state;
  logic            started;
  logic [XLEN-1:0] fetch_pc, resp_pc;
  logic [CW-1:0]   outstanding, outstanding_nxt, discard, fifo_count;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [XLEN-1:0] head_pc, head_inst;
  logic            grant, resp_accept, resp_drop, resp_keep, credit_ok;

  // Responses with nothing outstanding are spurious and ignored.
  assign resp_accept = inst.data_gnt && (outstanding != '0);
  assign resp_drop   = resp_accept && (state == DRAIN || redirect_valid);
  assign resp_keep   = resp_accept && !resp_drop;
  assign grant       = inst.req && inst.gnt;

  // Every issued request must have a guaranteed queue slot when it returns.
  assign credit_ok = (({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH))
                  && (outstanding < CW'(MAX_OUTSTANDING)) && !fifo_full;

  // started holds req low during reset and its first released cycle.
  assign inst.req   = started && credit_ok && !redirect_valid;
  assign inst.addr  = fetch_pc;
  assign inst.wstrb = '0;

  always_comb begin
    outstanding_nxt = outstanding;
    if (grant && !resp_accept)      outstanding_nxt = outstanding + 1'b1;
    else if (!grant && resp_accept) outstanding_nxt = outstanding - 1'b1;
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state       <= RUN;
      started     <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old stream.
        fetch_pc <= word_align(redirect_pc);
        resp_pc  <= word_align(redirect_pc);
        discard  <= outstanding_nxt;
        state    <= (outstanding_nxt != '0) ? DRAIN : RUN;
      end else begin
        if (grant)     fetch_pc <= fetch_pc + XLEN'(4);
        if (resp_keep) resp_pc  <= resp_pc + XLEN'(4);
        if (resp_drop) begin
          discard <= discard - 1'b1;
          if (discard == CW'(1)) state <= RUN;
        end
      end
    end
  end

`ifdef LADYBIRD_FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = resp_keep && fifo_empty;
  assign o_valid   = !fifo_empty || bypass;
  assign o_inst    = bypass ? inst.data : head_inst;
  assign o_pc      = bypass ? resp_pc   : head_pc;
  // A bypassed word taken immediately never needs storing.
  assign fifo_push = resp_keep && !(bypass && i_ready);
  assign fifo_pop  = !fifo_empty && i_ready && !redirect_valid;
`else
  assign o_valid   = !fifo_empty;
  assign o_inst    = head_inst;
  assign o_pc      = head_pc;
  assign fifo_push = resp_keep;
  assign fifo_pop  = !fifo_empty && i_ready && !redirect_valid;
`endif

  ladybird_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .anrst     (anrst),
    .push      (fifo_push),
    .push_pc   (resp_pc),
    .push_inst (inst.data),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_pc   (head_pc),
    .head_inst (head_inst)
  );

  if (SIMULATION) begin : g_sim_chk
    always_ff @(posedge clk) begin
      if (anrst && inst.data_gnt && outstanding == '0)
        $error("ladybird_fetch_queue: data_gnt with no request outstanding");
    end
  end

endmodule

// File: tb/tb_ladybird_fetch_queue.sv
module tb_ladybird_fetch_queue;
  import ladybird_config::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        anrst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        o_valid;
  logic [31:0] o_inst, o_pc;
  logic        i_ready;

  ladybird_mem_if inst_if ();

  ladybird_fetch_queue #(
    .RESET_PC(RESET_PC), .DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .anrst(anrst), .inst(inst_if),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .o_valid(o_valid), .o_inst(o_inst), .o_pc(o_pc), .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int grants   = 0;
  int pops     = 0;
  int epoch    = 0;
  logic        hold = 1'b0;
  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] last_grant = '0;

  // bus model: granted addresses awaiting a response, tagged with stream epoch
  int          pend_ep [$];
  logic [31:0] pend_a  [$];
  // scoreboard of words the consumer should see, in order
  logic [31:0] exq_pc   [$];
  logic [31:0] exq_inst [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_true(input string tag, input logic cond);
    n_checks++;
    assert (cond === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected 1", tag, cond);
    end
  endtask

  // One clock: inspect outputs at the falling edge, then drive the bus
  // response and redirect for the next cycle just after the rising edge.
  task automatic cycle(input logic r, input logic [31:0] rpc);
    logic g, dg;
    logic [31:0] a, pc_e, in_e;
    @(negedge clk);
    if (redirect_valid) check("req_in_redirect", {31'b0, inst_if.req}, 32'h0);
    if (inst_if.req && inst_if.gnt) begin
      grants++;
      last_grant = inst_if.addr;
      check("fetch_addr", inst_if.addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (o_valid && i_ready && !redirect_valid) begin
      pops++;
      check_true("sb_has_entry", exq_pc.size() != 0);
      if (exq_pc.size() != 0) begin
        pc_e = exq_pc.pop_front();
        in_e = exq_inst.pop_front();
        check("pop_pc", o_pc, pc_e);
        check("pop_inst", o_inst, in_e);
      end
    end
    g  = inst_if.req && inst_if.gnt;
    a  = inst_if.addr;
    dg = inst_if.data_gnt;
    @(posedge clk);
    #1;
    if (dg && pend_a.size() != 0) begin
      void'(pend_a.pop_front());
      void'(pend_ep.pop_front());
    end
    if (g) begin
      pend_a.push_back(a);
      pend_ep.push_back(epoch);
    end
    if (!hold && pend_a.size() != 0) begin
      inst_if.data_gnt = 1'b1;
      inst_if.data     = pend_a[0] + 32'h13;
      if (pend_ep[0] == epoch) begin
        exq_pc.push_back(pend_a[0]);
        exq_inst.push_back(pend_a[0] + 32'h13);
      end
    end else begin
      inst_if.data_gnt = 1'b0;
    end
    redirect_valid = r;
    redirect_pc    = rpc;
    if (r) begin
      epoch++;
      exp_fetch = {rpc[31:2], 2'b00};
      exq_pc.delete();
      exq_inst.delete();
    end
  endtask

  initial begin
    int n;
    logic [31:0] tgt;
    anrst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    i_ready = 1'b1;
    inst_if.gnt = 1'b0;
    inst_if.data_gnt = 1'b0;
    inst_if.data = '0;

    // reset state
    #2;
    check("rst_o_valid", {31'b0, o_valid}, 32'h0);
    check("rst_req", {31'b0, inst_if.req}, 32'h0);
    check("rst_o_pc", o_pc, 32'h0);
    check("rst_o_inst", o_inst, 32'h0);
    check("rst_addr", inst_if.addr, RESET_PC);
    @(posedge clk);
    #1;
    anrst = 1'b1;
    inst_if.gnt = 1'b1;

    // first response into an empty queue
    n = 0;
    do begin cycle(1'b0, '0); n++; end while (!inst_if.data_gnt && n < 10);
    check_true("first_resp_seen", inst_if.data_gnt);
    #1;
`ifdef LADYBIRD_FETCH_BYPASS_EN
    check("bypass_o_valid", {31'b0, o_valid}, 32'h1);
    check("bypass_o_inst", o_inst, 32'h13);
    check("bypass_o_pc", o_pc, 32'h0);
`else
    check("nobypass_o_valid", {31'b0, o_valid}, 32'h0);
    cycle(1'b0, '0);
    #1;
    check("lat1_o_valid", {31'b0, o_valid}, 32'h1);
    check("lat1_o_inst", o_inst, 32'h13);
    check("lat1_o_pc", o_pc, 32'h0);
`endif

    // streaming with gnt=1, i_ready=1
    pops = 0;
    repeat (20) cycle(1'b0, '0);
    check_true("stream_throughput", pops >= 18);

    // consumer stalls: queue fills, req stays low while full
    i_ready = 1'b0;
    repeat (8) cycle(1'b0, '0);
    grants = 0;
    repeat (4) begin
      cycle(1'b0, '0);
      #1;
      check("full_req_low", {31'b0, inst_if.req}, 32'h0);
      check("full_o_valid", {31'b0, o_valid}, 32'h1);
    end
    check("full_no_grants", grants, 32'd0);
    pops = 0;
    i_ready = 1'b1;
    cycle(1'b0, '0);
    i_ready = 1'b0;
    grants = 0;
    repeat (5) cycle(1'b0, '0);
    check("pulse_pops", pops, 32'd1);
    check("pulse_grants", grants, 32'd1);

    // redirect with two requests outstanding
    hold = 1'b1;
    i_ready = 1'b1;
    repeat (8) cycle(1'b0, '0);
    check("pending_before_redirect", pend_a.size(), 32'd2);
    cycle(1'b1, 32'h0000_0100);
    hold = 1'b0;
    cycle(1'b0, '0);
    #1;
    check("redir_o_valid_next", {31'b0, o_valid}, 32'h0);
    n = 0;
    while (!o_valid && n < 12) begin cycle(1'b0, '0); #1; n++; end
    check("redir_first_pc", o_pc, 32'h0000_0100);
    check("redir_first_inst", o_inst, 32'h0000_0113);

    // redirect coinciding with a response and i_ready, unaligned target
    repeat (6) cycle(1'b0, '0);
    cycle(1'b1, 32'h0000_0202);
    check_true("resp_in_redirect_cycle", inst_if.data_gnt);
    cycle(1'b0, '0);
    #1;
    check("redir2_o_valid_next", {31'b0, o_valid}, 32'h0);
    n = 0;
    while (!o_valid && n < 12) begin cycle(1'b0, '0); #1; n++; end
    check("redir2_first_pc", o_pc, 32'h0000_0200);
    check("redir2_first_inst", o_inst, 32'h0000_0213);
    repeat (6) cycle(1'b0, '0);

    // reset with requests outstanding and entries queued
    i_ready = 1'b0;
    repeat (3) cycle(1'b0, '0);
    hold = 1'b1;
    repeat (3) cycle(1'b0, '0);
    #2;
    anrst = 1'b0;
    inst_if.data_gnt = 1'b0;
    pend_a.delete();
    pend_ep.delete();
    exq_pc.delete();
    exq_inst.delete();
    epoch++;
    exp_fetch = RESET_PC;
    #1;
    check("arst_o_valid", {31'b0, o_valid}, 32'h0);
    check("arst_req", {31'b0, inst_if.req}, 32'h0);
    check("arst_o_pc", o_pc, 32'h0);
    @(posedge clk);
    #1;
    anrst = 1'b1;
    hold = 1'b0;
    i_ready = 1'b1;
    grants = 0;
    n = 0;
    while (grants == 0 && n < 10) begin cycle(1'b0, '0); n++; end
    check_true("post_reset_grant_seen", grants != 0);
    check("post_reset_first_addr", last_grant, RESET_PC);
    repeat (10) cycle(1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ladybird_fetch_queue.md
LADYBIRD_FETCH_QUEUE -- requirements
Module: ladybird_fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, the queue entry count; it SHALL be a power of two, 2..16.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, the maximum issued-but-unanswered requests; it SHALL be in the range 1..DEPTH.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port anrst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port inst, interface.primary: fetch bus; this block drives req, addr and wstrb='0 and samples gnt, data_gnt and data (XLEN bits).
REQ-007 Port redirect_valid, input, 1 bit: flush the queue and restart fetch at redirect_pc.
REQ-008 Port redirect_pc, input, XLEN bits: new fetch address; bits [1:0] SHALL be ignored and treated as 0.
REQ-009 Port o_valid, output, 1 bit: the head entry is valid.
REQ-010 Port o_inst, output, XLEN bits: head instruction word.
REQ-011 Port o_pc, output, XLEN bits: address of the head instruction.
REQ-012 Port i_ready, input, 1 bit: consumer accepts the head this cycle.

Function
REQ-013 The block SHALL assert inst.req when (occupancy + outstanding) < DEPTH, outstanding < MAX_OUTSTANDING and redirect_valid=0.
REQ-014 inst.addr SHALL equal fetch_pc; on inst.req & inst.gnt, fetch_pc SHALL advance by 4 and outstanding SHALL increment.
REQ-015 Responses SHALL be in order; each inst.data_gnt SHALL decrement outstanding and push {resp_pc, inst.data}; resp_pc SHALL then advance by 4.
REQ-016 A grant and a response in the same cycle SHALL leave outstanding unchanged.
REQ-017 Pop SHALL occur on o_valid & i_ready; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-018 Read and write pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH, and use a separate occupancy counter for full/empty.
REQ-019 With registered output, push-to-o_valid latency SHALL be 1 cycle.
REQ-020 On redirect_valid: the queue SHALL empty, o_valid SHALL be 0 the next cycle, and fetch_pc and resp_pc SHALL load redirect_pc.
REQ-021 On redirect_valid: discard SHALL load the outstanding count after that cycle's response, if any.
REQ-022 While discard>0, each data_gnt SHALL decrement discard and SHALL be dropped, not pushed.
REQ-023 Redirect SHALL override a same-cycle push and pop; a response in the redirect cycle SHALL be dropped.
REQ-024 inst.req SHALL be 0 in the redirect cycle, so no stale-address grant can occur.
REQ-025 Fetch SHALL be a two-state FSM: RUN and DRAIN; DRAIN holds while discard>0; requests for the new pc MAY issue in DRAIN, subject to the credit rule.
REQ-026 A data_gnt with outstanding=0 SHALL be ignored (SIMULATION=1: $error).

Reset
REQ-027 On anrst low the block SHALL set fetch_pc=resp_pc=RESET_PC, occupancy=outstanding=discard=0, FSM=RUN, o_valid=0, inst.req=0, and o_inst=o_pc='0.
REQ-028 Reset mid-transaction SHALL abandon in-flight requests; the bus is reset concurrently.

Configuration
REQ-029 Macro LADYBIRD_FETCH_BYPASS_EN SHALL control a bypass path.
REQ-030 With LADYBIRD_FETCH_BYPASS_EN defined: when the queue is empty and a response is accepted, o_valid, o_inst and o_pc SHALL present it the same cycle (0-cycle latency).
REQ-031 In bypass, if i_ready=1 the entry SHALL NOT be written to the queue.
REQ-032 Without LADYBIRD_FETCH_BYPASS_EN, outputs SHALL come from storage only, giving 1-cycle latency.

Structure
REQ-033 XLEN SHALL come from ladybird_config.
REQ-034 The fetch FSM state typedef (RUN, DRAIN) SHALL be added to ladybird_config.
REQ-035 Storage SHALL be one sub-module, ladybird_fetch_fifo (DEPTH x {pc, inst}, push/pop/flush, full/empty); credit, discard and FSM logic SHALL stay in the top.

Verification
REQ-036 Reset release, bus gnt=1 and data_gnt one cycle after each grant, i_ready=1 -> o_pc sequence 0x0, 0x4, 0x8, ...; inst.addr never repeats or skips.
REQ-037 i_ready=0 with DEPTH=4 -> exactly 4 grants; inst.req=0 while full; first i_ready pulse -> one pop and one new request.
REQ-038 Redirect to 0x100 with 2 outstanding -> the next 2 responses are dropped; first o_pc=0x100 carries the data of the request addressed 0x100.
REQ-039 Redirect in the same cycle as data_gnt and i_ready -> no push, no pop visible; o_valid=0 next cycle; discard = remaining outstanding.
REQ-040 LADYBIRD_FETCH_BYPASS_EN defined, empty queue, response with data 32'h0000_0013 -> o_valid=1 and o_inst=32'h13 the same cycle; undefined -> one cycle later.
REQ-041 anrst asserted with 2 outstanding and 3 queued -> o_valid=0 immediately; after release first inst.addr=RESET_PC.
